// File: rtl/resp_misr_checker.sv
`default_nettype none
// ============================================================================
// Module      : resp_misr_checker
// Description : Compacts a stream of circuit response words into a MISR
//               signature, then compares the final signature against a
//               golden value and reports pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_misr_checker #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h0040_0007,
    parameter logic [WIDTH-1:0] SEED  = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_vectors,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    output logic             resp_ready,
    output logic [WIDTH-1:0] sig,
    output logic [15:0]      count,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sig;
    logic [15:0]      r_count;
    logic [15:0]      r_nv;
    logic             r_pass;

    logic             w_xfer;
    logic             w_launch;
    logic [15:0]      w_count_inc;
    logic [WIDTH-1:0] w_sig_next;

    // A session may be launched only from IDLE or DONE; RUN/CHECK ignore start.
    assign w_launch    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_xfer      = (r_state == RUN) && resp_valid;
    assign w_count_inc = r_count + 16'd1;
    assign w_sig_next  = {r_sig[WIDTH-2:0], 1'b0}
                       ^ (r_sig[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                       ^ resp;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        resp_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (num_vectors == 16'd0) ? CHECK : RUN;
                end
            end
            RUN: begin
                resp_ready = 1'b1;
                busy       = 1'b1;
                // The transfer that reaches the latched length ends capture.
                if (w_xfer && (w_count_inc == r_nv)) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next = (num_vectors == 16'd0) ? CHECK : RUN;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Signature, word counter, latched length and verdict registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig   <= SEED;
            r_count <= 16'd0;
            r_nv    <= 16'd0;
            r_pass  <= 1'b0;
        end else if (w_launch) begin
            r_sig   <= SEED;
            r_count <= 16'd0;
            r_nv    <= num_vectors;
            r_pass  <= 1'b0;
        end else if (w_xfer) begin
            // resp is only looked at here, so idle-cycle garbage is harmless
            r_sig   <= w_sig_next;
            r_count <= w_count_inc;
        end else if (r_state == CHECK) begin
            r_pass  <= (r_sig == golden_sig);
        end
    end

    assign sig   = r_sig;
    assign count = r_count;
    assign pass  = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_resp_misr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_misr_checker
// Description : Randomized scoreboard bench for resp_misr_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_misr_checker;

    localparam logic [31:0] C_POLY = 32'h0040_0007;
    localparam logic [31:0] C_SEED = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_vectors;
    logic [31:0] golden_sig;
    logic        resp_valid;
    logic [31:0] resp;
    logic        resp_ready;
    logic [31:0] sig;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        pass;

    resp_misr_checker dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_vectors (num_vectors),
        .golden_sig  (golden_sig),
        .resp_valid  (resp_valid),
        .resp        (resp),
        .resp_ready  (resp_ready),
        .sig         (sig),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .pass        (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sig;
        logic [15:0] count;
        logic        pass;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        done_q   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Signature update as polynomial arithmetic: multiply by x modulo
    // P(x) = x^32 + POLY, then add the incoming word.
    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] w);
        logic [32:0] prod;
        prod = {s, 1'b0};
        if (prod[32]) prod = prod ^ {1'b1, C_POLY};
        return prod[31:0] ^ w;
    endfunction

    // Monitor: every rising edge of done retires one scoreboard entry.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_sig",   64'(sig),   64'(e.sig));
                chk("sb_count", 64'(count), 64'(e.count));
                chk("sb_pass",  64'(pass),  64'(e.pass));
            end
        end
        done_q <= done;
    end

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    // Runs one full session over the words in wq.
    task automatic run_session(input int nv, input bit good, input int stall_pct, input bit mid_start);
        logic [31:0] full_sig;
        logic [31:0] run_sig;
        logic [31:0] g;
        exp_t        e;
        int          idx;
        int          cyc;
        bit          v;
        bit          xfer;
        bit          pulsed;

        full_sig = C_SEED;
        for (int i = 0; i < nv; i++) full_sig = misr_step(full_sig, wq[i]);
        g = good ? full_sig : (full_sig ^ ($urandom | 32'h1));

        @(posedge clk); #1;
        start = 1'b1; num_vectors = 16'(nv); golden_sig = g;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_count", 64'(count), 64'd0);
        chk("start_sig",   64'(sig),   64'(C_SEED));

        run_sig = C_SEED;
        idx     = 0;
        cyc     = 0;
        pulsed  = 1'b0;
        while (idx < nv) begin
            v          = ($urandom_range(99) >= stall_pct);
            resp_valid = v;
            resp       = v ? wq[idx] : $urandom;
            if (mid_start && idx == 1 && !pulsed) begin
                start       = 1'b1;
                num_vectors = 16'd5;
                pulsed      = 1'b1;
            end
            @(negedge clk);
            chk("ready_in_run", 64'(resp_ready), 64'd1);
            xfer = v && resp_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (xfer) begin
                run_sig = misr_step(run_sig, wq[idx]);
                idx++;
            end
            chk("step_count", 64'(count), 64'(idx));
            chk("step_sig",   64'(sig),   64'(run_sig));
            cyc++;
            if (cyc > 5000) begin
                chk("xfer_timeout", 64'd1, 64'd0);
                break;
            end
        end
        resp_valid = 1'b0;
        resp       = $urandom;

        e.sig = full_sig; e.count = 16'(nv); e.pass = good;
        exp_q.push_back(e);

        chk("ready_low_in_check", 64'(resp_ready), 64'd0);
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_latency", 64'(cyc), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("hold_done",  64'(done),  64'd1);
        chk("hold_count", 64'(count), 64'(nv));
        chk("hold_sig",   64'(sig),   64'(full_sig));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sig"},   64'(sig),        64'(C_SEED));
        chk({tag, "_count"}, 64'(count),      64'd0);
        chk({tag, "_ready"}, 64'(resp_ready), 64'd0);
        chk({tag, "_busy"},  64'(busy),       64'd0);
        chk({tag, "_done"},  64'(done),       64'd0);
        chk({tag, "_pass"},  64'(pass),       64'd0);
    endtask

    // Starts a session and feeds n words with no stalls, no checking.
    task automatic partial_session(input int nv, input int n);
        fill_random(n);
        @(posedge clk); #1;
        start = 1'b1; num_vectors = 16'(nv);
        @(posedge clk); #1;
        start = 1'b0;
        resp_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            resp = wq[i];
            @(posedge clk); #1;
        end
        resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vectors = '0; golden_sig = '0;
        resp_valid = 1'b0; resp = '0;
        #1;
        check_reset_values("por");
        #21 rst = 1'b0;

        // Single zero word from the default seed: known signature.
        wq.delete(); wq.push_back(32'h0);
        run_session(1, 1'b1, 0, 1'b0);
        chk("known_sig", 64'(sig), 64'h0000_0000_FFBF_FFF9);
        chk("known_pass", 64'(pass), 64'd1);
        run_session(1, 1'b0, 0, 1'b0);
        chk("known_fail", 64'(pass), 64'd0);

        // Empty session: signature stays at seed.
        wq.delete();
        run_session(0, 1'b1, 0, 1'b0);

        // Stalled short session and randomized sessions.
        fill_random(3);
        run_session(3, 1'b1, 50, 1'b0);
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(20, 1);
            fill_random(n);
            run_session(n, ($urandom_range(1) == 1), $urandom_range(60), 1'b0);
        end

        // Start pulse while in RUN must be ignored.
        fill_random(8);
        run_session(8, 1'b1, 20, 1'b1);

        // Asynchronous reset mid-session, then a clean rerun.
        partial_session(10, 5);
        #2 rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        #4 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_restart_busy", 64'(busy), 64'd0);
        fill_random(10);
        run_session(10, 1'b1, 30, 1'b0);

        // Maximum length is latched without being treated as empty.
        partial_session(16'hFFFF, 3);
        chk("max_len_busy",  64'(busy),       64'd1);
        chk("max_len_count", 64'(count),      64'd3);
        chk("max_len_ready", 64'(resp_ready), 64'd1);
        #2 rst = 1'b1;
        #5 rst = 1'b0;

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
